// File: rtl/scytale_encryption_if.sv
// Character stream bus for the scytale encryptor: plaintext in, ciphertext out.
// The master side (stimulus / upstream block) drives the plaintext and keys;
// the slave side (the encryptor) drives busy and the ciphertext stream.
interface scytale_encryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
);
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key_N;
    logic [KEY_WIDTH-1:0] key_M;
    logic                 busy;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;

    modport master (
        output data_i, valid_i, key_N, key_M,
        input  busy, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, key_N, key_M,
        output busy, data_o, valid_o
    );
endinterface

// File: rtl/scytale_encryption.sv
// Scytale encryptor. Collects plaintext characters into a buffer until the
// start token arrives, then reads the buffer out column-major (row index runs
// fastest over key_M rows of key_N characters) one character per cycle.
// The read address is tracked incrementally (add key_N per row step, restart
// at the next column on row wrap) so no multiplier or divider sits in the loop.
module scytale_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
    input  logic                  clk,
    input  logic                  rst,
    scytale_encryption_if.slave   bus
);
    localparam int IDX_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int L_W   = 2 * KEY_WIDTH;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NOF_CHARS);
    localparam logic [L_W-1:0]   MAX_LEN = L_W'(MAX_NOF_CHARS);

    typedef enum logic {
        COLLECT = 1'b0,
        ENCRYPT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
    logic [D_WIDTH-1:0]   buf_d [MAX_NOF_CHARS];
    logic [KEY_WIDTH-1:0] keym_q, keym_d;
    logic [KEY_WIDTH-1:0] keyn_q, keyn_d;
    logic [L_W-1:0]       len_q, len_d;
    logic [KEY_WIDTH-1:0] row_q, row_d;
    logic [KEY_WIDTH-1:0] col_q, col_d;
    logic [L_W-1:0]       pos_q, pos_d;
    logic [L_W-1:0]       emitted_q, emitted_d;
    logic                 busy_q, busy_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic                 valid_q, valid_d;

    assign bus.busy    = busy_q;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;

    // Next-state and registered-output logic for collection and readout.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        keym_d    = keym_q;
        keyn_d    = keyn_q;
        len_d     = len_q;
        row_d     = row_q;
        col_d     = col_q;
        pos_d     = pos_q;
        emitted_d = emitted_q;
        busy_d    = busy_q;
        data_d    = '0;
        valid_d   = 1'b0;

        case (state_q)
            COLLECT: begin
                if (bus.valid_i) begin
                    if (bus.data_i == START_ENCRYPTION_TOKEN) begin
                        // Keys are frozen here; later key changes wait for the next token.
                        keym_d    = bus.key_M;
                        keyn_d    = bus.key_N;
                        len_d     = L_W'(bus.key_M) * L_W'(bus.key_N);
                        row_d     = '0;
                        col_d     = '0;
                        pos_d     = '0;
                        emitted_d = '0;
                        busy_d    = 1'b1;
                        state_d   = ENCRYPT;
                    end else if (count_q < MAX_CNT) begin
                        // A full buffer silently drops further characters.
                        buf_d[count_q[IDX_W-1:0]] = bus.data_i;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end

            ENCRYPT: begin
                if ((len_q != '0) && (len_q <= MAX_LEN) && (emitted_q < len_q)) begin
                    // pos_q < len_q <= MAX_NOF_CHARS, so the low bits address the buffer.
                    data_d    = buf_q[pos_q[IDX_W-1:0]];
                    valid_d   = 1'b1;
                    emitted_d = emitted_q + L_W'(1);
                    if (row_q == keym_q - KEY_WIDTH'(1)) begin
                        row_d = '0;
                        col_d = col_q + KEY_WIDTH'(1);
                        pos_d = L_W'(col_q) + L_W'(1);
                    end else begin
                        row_d = row_q + KEY_WIDTH'(1);
                        pos_d = pos_q + L_W'(keyn_q);
                    end
                end else begin
                    // Done, or keys describe an empty/oversized grid: drop back to collection.
                    state_d = COLLECT;
                    busy_d  = 1'b0;
                    count_d = '0;
                    for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                        buf_d[i] = '0;
                    end
                end
            end

            default: begin
                state_d = COLLECT;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, buffer and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                buf_q[i] <= '0;
            end
            keym_q    <= '0;
            keyn_q    <= '0;
            len_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pos_q     <= '0;
            emitted_q <= '0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            keym_q    <= keym_d;
            keyn_q    <= keyn_d;
            len_q     <= len_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pos_q     <= pos_d;
            emitted_q <= emitted_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: tb/tb_scytale_encryption.sv
// Bench for the scytale encryptor: table of known messages, hand-written
// corner sequences (long message, interfering input, mid-output reset) and
// randomized messages checked against a position-formula reference model.
module tb_scytale_encryption;
    localparam int         D_WIDTH   = 8;
    localparam int         KEY_WIDTH = 8;
    localparam int         MAX_CHARS = 50;
    localparam logic [7:0] TOKEN     = 8'hFA;

    logic clk = 1'b0;
    logic rst = 1'b0;

    scytale_encryption_if #(.D_WIDTH(D_WIDTH), .KEY_WIDTH(KEY_WIDTH)) bus ();

    scytale_encryption #(
        .D_WIDTH(D_WIDTH),
        .KEY_WIDTH(KEY_WIDTH),
        .MAX_NOF_CHARS(MAX_CHARS),
        .START_ENCRYPTION_TOKEN(TOKEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] msg_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        string msg;
        int    m;
        int    n;
        string expect_s;   // '_' stands for a 0x00 character
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: character k comes from row (k mod M), column (k div M) of an
    // M x N row-major grid; positions beyond the kept text read as 0x00.
    function automatic void build_expected(input int m, input int n);
        int l;
        int kept;
        l    = m * n;
        kept = (msg_q.size() > MAX_CHARS) ? MAX_CHARS : msg_q.size();
        exp_q.delete();
        if (l == 0 || l > MAX_CHARS) return;
        for (int k = 0; k < l; k++) begin
            int pos;
            pos = (k % m) * n + (k / m);
            exp_q.push_back((pos < kept) ? msg_q[pos] : 8'h00);
        end
    endfunction

    task automatic load_msg(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
    endtask

    task automatic load_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back((s[i] == "_") ? 8'h00 : 8'(s[i]));
    endtask

    // Send msg_q then the token; check busy/valid_o/data_o every cycle against exp_q.
    // With noise set, valid_i (alternating 'Q' and the token) and random keys are
    // driven throughout the busy window, including the edge that returns to collection.
    task automatic send_and_check(input string name, input int m, input int n, input bit noise);
        int busy_len;
        busy_len = exp_q.size() + 1;
        bus.key_M = 8'(m);
        bus.key_N = 8'(n);
        foreach (msg_q[i]) begin
            bus.valid_i = 1'b1;
            bus.data_i  = msg_q[i];
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b1;
        bus.data_i  = TOKEN;
        @(posedge clk); #1;
        check({name, ".busy@T"},  32'(bus.busy),    32'd1);
        check({name, ".valid@T"}, 32'(bus.valid_o), 32'd0);
        for (int c = 1; c <= busy_len; c++) begin
            if (noise) begin
                bus.valid_i = 1'b1;
                bus.data_i  = (c % 2 == 1) ? 8'h51 : TOKEN;
                bus.key_M   = 8'($urandom);
                bus.key_N   = 8'($urandom);
            end else begin
                bus.valid_i = 1'b0;
            end
            @(posedge clk); #1;
            check({name, ".busy"},  32'(bus.busy),    32'(c < busy_len));
            check({name, ".valid"}, 32'(bus.valid_o), 32'(c < busy_len));
            check({name, ".data"},  32'(bus.data_o),  (c < busy_len) ? 32'(exp_q[c-1]) : 32'd0);
        end
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
    endtask

    initial begin
        vecs[0] = '{msg: "ABCDEF", m: 2, n: 3, expect_s: "ADBECF"};
        vecs[1] = '{msg: "ABCDEF", m: 3, n: 2, expect_s: "ACEBDF"};
        vecs[2] = '{msg: "UVWXYZ", m: 3, n: 2, expect_s: "UWYVXZ"};
        vecs[3] = '{msg: "AB",     m: 2, n: 2, expect_s: "A_B_"};
        vecs[4] = '{msg: "",       m: 0, n: 2, expect_s: ""};
        vecs[5] = '{msg: "",       m: 1, n: 3, expect_s: "___"};
        vecs[6] = '{msg: "HI",     m: 8, n: 8, expect_s: ""};

        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.key_M   = 8'h00;
        bus.key_N   = 8'h00;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset.busy",  32'(bus.busy),    32'd0);
        check("reset.valid", 32'(bus.valid_o), 32'd0);
        check("reset.data",  32'(bus.data_o),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle.busy",  32'(bus.busy),    32'd0);
        check("idle.valid", 32'(bus.valid_o), 32'd0);

        // Table of known messages, run back to back
        for (int v = 0; v < 7; v++) begin
            load_msg(vecs[v].msg);
            load_exp(vecs[v].expect_s);
            send_and_check($sformatf("vec%0d", v), vecs[v].m, vecs[v].n, 1'b0);
        end

        // 55 characters into a 50-deep buffer, with interfering input during output
        msg_q.delete();
        for (int i = 0; i < 55; i++) msg_q.push_back(8'(8'h61 + i));
        build_expected(5, 10);
        check("long.len", 32'(exp_q.size()), 32'd50);
        send_and_check("long", 5, 10, 1'b1);

        // Asynchronous reset in the middle of the output stream
        load_msg("ABCDEF");
        bus.key_M = 8'd2;
        bus.key_N = 8'd3;
        foreach (msg_q[i]) begin
            bus.valid_i = 1'b1;
            bus.data_i  = msg_q[i];
            @(posedge clk); #1;
        end
        bus.data_i = TOKEN;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid.valid", 32'(bus.valid_o), 32'd1);
        check("mid.data",  32'(bus.data_o),  32'h42);
        #2 rst = 1'b1;
        #1;
        check("async.busy",  32'(bus.busy),    32'd0);
        check("async.valid", 32'(bus.valid_o), 32'd0);
        check("async.data",  32'(bus.data_o),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_msg("ABCDEF");
        load_exp("ADBECF");
        send_and_check("after_rst", 2, 3, 1'b0);

        // Randomized messages against the reference model
        for (int r = 0; r < 10; r++) begin
            int len, m, n;
            len = $urandom_range(0, 55);
            msg_q.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] ch;
                ch = 8'($urandom_range(0, 255));
                if (ch == TOKEN) ch = 8'h41;
                msg_q.push_back(ch);
            end
            if ($urandom_range(0, 3) == 0) begin
                m = $urandom_range(0, 12);
                n = $urandom_range(0, 12);
            end else begin
                m = $urandom_range(1, 7);
                n = $urandom_range(1, 7);
            end
            build_expected(m, n);
            send_and_check($sformatf("rand%0d_m%0d_n%0d", r, m, n), m, n, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit reached");
    end
endmodule
